arm_trace_buffer: RTL
=====================

Name: arm_trace_buffer

Overview:
Trace capture stage downstream of the single-cycle ARM core (top `arm`). Every retired instruction (one per clock) is sampled as an entry {Instr, ALUResult, Result, ALUControl} into a FIFO. Entries drain over a 32-bit valid/ready stream, three beats per entry, to a debug/log sink. Capture stops on the halt instruction 0xE0000000, so benches and debug hardware get a lossless, back-pressurable retirement trace.

Parameters:
DEPTH, 16, FIFO entries; power of two, >=2
HALT_INSTR, 32'hE0000000, encoding that terminates capture
CNT_W, 16, width of the drop and retire counters

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-high
trace_en  in  1  capture enable
Instr  in  32  retiring instruction from core
ALUResult  in  32  core ALU result
Result  in  32  core writeback result
ALUControl  in  2  core ALU control
out_valid  out  1  beat valid
out_ready  in  1  sink accepts beat
out_data  out  32  beat payload
out_beat  out  2  beat index: 0=Instr, 1=ALUResult, 2=Result (3=timestamp, optional)
out_ctrl  out  2  ALUControl of current entry, constant across beats
out_last  out  1  final beat of entry
halted  out  1  halt instruction seen (sticky)
overflow  out  1  sticky: at least one entry dropped
drop_cnt  out  CNT_W  entries dropped, saturating
retire_cnt  out  CNT_W  entries accepted into FIFO, saturating
done  out  1  halted & FIFO empty & drain FSM IDLE

Behaviour:
- Reset (RST=1 at rising edge): FIFO pointers/count=0, FSM=IDLE, out_valid=0, out_data=0, out_beat=0, out_ctrl=0, out_last=0, halted=0, overflow=0, drop_cnt=0, retire_cnt=0. Reset mid-drain discards all entries; no beat is completed.
- Capture (push) condition per cycle: !RST & trace_en & !halted.
- Push accepted if count<DEPTH, or count==DEPTH with a pop (final-beat handshake) in the same cycle. Accepted push: write entry, retire_cnt+1 (saturate at all-ones).
- Push refused (full, no pop): entry discarded, drop_cnt+1 (saturating), overflow<=1.
- Halt: a captured cycle with Instr==HALT_INSTR is pushed like any other entry (or dropped if full). halted<=1 at that edge regardless. No further capture until reset.
- Count width clog2(DEPTH)+1. Read/write pointers wrap modulo DEPTH.
- Drain FSM states IDLE, B0, B1, B2.
  - IDLE -> B0 when count>0. out_valid=1 in every Bx state.
  - Bx advances only on out_valid&out_ready. B0->B1->B2.
  - B2 handshake pops the entry, then -> B0 if count-1>0 (or a same-cycle push), else IDLE.
- While out_valid & !out_ready, out_data/out_beat/out_ctrl/out_last hold stable.
- out_last=1 only in the final beat state.
- Latency: entry captured at edge k gives out_valid=1 at the cycle after edge k, beat 0 = its Instr. Minimum 3 cycles per entry at out_ready=1.
- Sustained output throughput is 1/3 of capture rate. Overflow under continuous capture is expected and must be counted exactly.
- done is combinational from registered state.

Optional Feature:
ARM_TRACE_TIMESTAMP_EN:
- Defined: a free-running 32-bit cycle counter (reset 0, wraps) is stored per entry. FSM gains state B3 carrying the timestamp, out_beat=3. out_last moves to B3, so each entry takes 4 beats.
- Undefined: no counter, no B3, out_last on B2.

Test Plan:
1. Reset, trace_en=1, out_ready=1; Instr=0xE2800005, 0xE2811003, then 0xE0000000 -> 9 beats in order (Instr, ALUResult, Result per entry), halted=1 after third edge, retire_cnt=3, drop_cnt=0, then done=1.
2. out_ready=0 for 10 cycles mid-beat 1 -> out_data stays the ALUResult of entry 0 with out_beat=1 throughout; resumes correctly when out_ready=1.
3. DEPTH=16, out_ready=0, 20 capture cycles -> retire_cnt=16, drop_cnt=4, overflow=1; drain yields exactly 16 entries, oldest first.
4. Full FIFO, final-beat handshake in same cycle as a push -> push accepted, count stays 16, drop_cnt unchanged.
5. Assert RST during B1 with 5 entries queued -> next cycle out_valid=0, all counters 0, halted=0; new capture restarts from an empty FIFO.
6. Hold trace_en=0 for 8 cycles, then 1 -> no entries for disabled cycles. With ARM_TRACE_TIMESTAMP_EN defined, beat 3 timestamps equal each capture's cycle index since reset and out_last fires on beat 3.

Source files
------------

// File: rtl/arm_trace_buffer.sv
// arm_trace_buffer: captures one retired-instruction record per clock into a
// FIFO and drains each record as a 3-beat 32-bit valid/ready stream
// (Instr, ALUResult, Result). Capture stops after the halt encoding.
// Optional macro ARM_TRACE_TIMESTAMP_EN adds a free-running cycle stamp per
// record, sent as a fourth beat that then carries out_last.
module arm_trace_buffer #(
  parameter int          DEPTH      = 16,
  parameter logic [31:0] HALT_INSTR = 32'hE0000000,
  parameter int          CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             trace_en,
  input  logic [31:0]      Instr,
  input  logic [31:0]      ALUResult,
  input  logic [31:0]      Result,
  input  logic [1:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [1:0]       out_beat,
  output logic [1:0]       out_ctrl,
  output logic             out_last,
  output logic             halted,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             done
);

  localparam int          AW     = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C  = (AW+1)'(1);

`ifdef ARM_TRACE_TIMESTAMP_EN
  typedef enum logic [2:0] {S_IDLE, S_B0, S_B1, S_B2, S_B3} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_B0, S_B1, S_B2} state_t;
`endif

  state_t            state_q, state_d;
  logic [AW:0]       count_q, count_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              halted_q, halted_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;

  logic [31:0]       instr_mem_q [DEPTH];
  logic [31:0]       alu_mem_q   [DEPTH];
  logic [31:0]       res_mem_q   [DEPTH];
  logic [1:0]        ctrl_mem_q  [DEPTH];

  logic              capture;
  logic              pop;
  logic              push_ok;
  logic              last_state;

`ifdef ARM_TRACE_TIMESTAMP_EN
  logic [31:0]       ts_q, ts_d;
  logic [31:0]       ts_mem_q [DEPTH];
  assign last_state = (state_q == S_B3);
`else
  assign last_state = (state_q == S_B2);
`endif

  // Handshake qualifiers; a final-beat pop frees a slot for a same-cycle push.
  always_comb begin
    capture = trace_en & ~halted_q;
    pop     = last_state & out_ready;
    push_ok = capture & ((count_q != FULL_C) | pop);
  end

  // FIFO bookkeeping, halt latch and saturating statistics.
  always_comb begin
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    halted_d     = halted_q;
    overflow_d   = overflow_q;
    drop_cnt_d   = drop_cnt_q;
    retire_cnt_d = retire_cnt_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (retire_cnt_q != '1) retire_cnt_d = retire_cnt_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (capture && !push_ok) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
    end
    if (capture && (Instr == HALT_INSTR)) halted_d = 1'b1;
  end

  // Drain FSM next state; IDLE also starts on a same-cycle push so the first
  // beat is visible the cycle after capture.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if ((count_q != '0) || push_ok) state_d = S_B0;
      S_B0:   if (out_ready) state_d = S_B1;
      S_B1:   if (out_ready) state_d = S_B2;
`ifdef ARM_TRACE_TIMESTAMP_EN
      S_B2:   if (out_ready) state_d = S_B3;
      S_B3:   if (out_ready) state_d = ((count_q > ONE_C) || push_ok) ? S_B0 : S_IDLE;
`else
      S_B2:   if (out_ready) state_d = ((count_q > ONE_C) || push_ok) ? S_B0 : S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

`ifdef ARM_TRACE_TIMESTAMP_EN
  // Free-running cycle stamp, wraps at 32 bits.
  always_comb ts_d = ts_q + 32'd1;
`endif

  // Control and status registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      halted_q     <= 1'b0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
      retire_cnt_q <= '0;
`ifdef ARM_TRACE_TIMESTAMP_EN
      ts_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      halted_q     <= halted_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
      retire_cnt_q <= retire_cnt_d;
`ifdef ARM_TRACE_TIMESTAMP_EN
      ts_q         <= ts_d;
`endif
    end
  end

  // Entry storage; written only on an accepted push, never reset.
  always_ff @(posedge CLK) begin
    if (!RST && push_ok) begin
      instr_mem_q[wr_ptr_q] <= Instr;
      alu_mem_q[wr_ptr_q]   <= ALUResult;
      res_mem_q[wr_ptr_q]   <= Result;
      ctrl_mem_q[wr_ptr_q]  <= ALUControl;
`ifdef ARM_TRACE_TIMESTAMP_EN
      ts_mem_q[wr_ptr_q]    <= ts_q;
`endif
    end
  end

  // Beat presentation from the head entry; stable while stalled because
  // neither the state nor the read pointer moves without a handshake.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_beat  = 2'd0;
    out_ctrl  = 2'd0;
    out_last  = 1'b0;
    case (state_q)
      S_B0: begin
        out_valid = 1'b1;
        out_data  = instr_mem_q[rd_ptr_q];
        out_beat  = 2'd0;
        out_ctrl  = ctrl_mem_q[rd_ptr_q];
      end
      S_B1: begin
        out_valid = 1'b1;
        out_data  = alu_mem_q[rd_ptr_q];
        out_beat  = 2'd1;
        out_ctrl  = ctrl_mem_q[rd_ptr_q];
      end
      S_B2: begin
        out_valid = 1'b1;
        out_data  = res_mem_q[rd_ptr_q];
        out_beat  = 2'd2;
        out_ctrl  = ctrl_mem_q[rd_ptr_q];
`ifndef ARM_TRACE_TIMESTAMP_EN
        out_last  = 1'b1;
`endif
      end
`ifdef ARM_TRACE_TIMESTAMP_EN
      S_B3: begin
        out_valid = 1'b1;
        out_data  = ts_mem_q[rd_ptr_q];
        out_beat  = 2'd3;
        out_ctrl  = ctrl_mem_q[rd_ptr_q];
        out_last  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign halted     = halted_q;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;
  assign retire_cnt = retire_cnt_q;
  assign done       = halted_q & (count_q == '0) & (state_q == S_IDLE);

endmodule
